// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, FSM states,
// the issue-entry record and the opcode legality check.
package cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_REG_AW = 5;
  localparam int CPU_OP_W   = 3;

  localparam logic [CPU_OP_W-1:0] OP_AND = 3'b000;
  localparam logic [CPU_OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [CPU_OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [CPU_OP_W-1:0] OP_SUB = 3'b011;
  localparam logic [CPU_OP_W-1:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [CPU_DATA_W-1:0] a;
    logic [CPU_DATA_W-1:0] b;
    logic [CPU_OP_W-1:0]   op;
    logic [CPU_REG_AW-1:0] rd;
    logic                  reg_write;
    logic                  illegal;
    logic                  use_imm;
    logic [CPU_REG_AW-1:0] rs1;
    logic [CPU_REG_AW-1:0] rs2;
  } issue_entry_t;

  function automatic logic op_is_legal(input logic [CPU_OP_W-1:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_issue_fwd_mux.sv
// Writeback-to-operand forwarding select for one op's a/b operands.
// Register x0 never forwards. b passes through untouched when it holds an
// immediate, since the immediate does not come from a register.
module alu_issue_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              fwd_valid,
  input  logic [REG_AW-1:0] fwd_rd,
  input  logic [DATA_W-1:0] fwd_data,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic              b_is_imm,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b
);

  logic fwd_live;
  assign fwd_live = fwd_valid & (fwd_rd != '0);

  // Replace each source with the writeback value when it names fwd_rd.
  always_comb begin
    a = rs1_data;
    b = rs2_data;
    if (fwd_live && (fwd_rd == rs1_addr)) a = fwd_data;
    if (fwd_live && !b_is_imm && (fwd_rd == rs2_addr)) b = fwd_data;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage feeding the ALU: a main entry that drives
// out_* and a one-deep skid entry so ALU back-pressure never drops an op.
// Optional feature macro: FORWARDING_EN (writeback forwarding into captured
// and held operands; fwd_* ports exist only when it is defined).
// Parameters must match the widths in cpu_pkg, which sizes the entry record.
//
// state    | meaning
// ST_EMPTY | no op held, out_valid = 0
// ST_FULL  | main entry holds an op, skid empty
// ST_SKID  | main and skid both hold ops, in_ready = 0
module alu_issue_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW,
  parameter int OP_W   = CPU_OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [DATA_W-1:0] in_rs1_data,
  input  logic [DATA_W-1:0] in_rs2_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [OP_W-1:0]   in_alu_control,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              flush,
`ifdef FORWARDING_EN
  input  logic              fwd_valid,
  input  logic [REG_AW-1:0] fwd_rd,
  input  logic [DATA_W-1:0] fwd_data,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [OP_W-1:0]   out_alu_control,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_illegal
);

  issue_state_e state;
  issue_entry_t main_q, skid_q;
  issue_entry_t cap, main_ref, skid_ref;

  logic              accept, consume;
  logic              fwd_v;
  logic [REG_AW-1:0] fwd_r;
  logic [DATA_W-1:0] fwd_d;
  logic [DATA_W-1:0] cap_a, cap_b, main_a, main_b, skid_a, skid_b;

`ifdef FORWARDING_EN
  assign fwd_v = fwd_valid;
  assign fwd_r = fwd_rd;
  assign fwd_d = fwd_data;
`else
  assign fwd_v = 1'b0;
  assign fwd_r = '0;
  assign fwd_d = '0;
`endif

  assign accept  = in_valid & in_ready & ~flush;
  assign consume = out_valid & out_ready;

  alu_issue_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_cap (
    .fwd_valid(fwd_v), .fwd_rd(fwd_r), .fwd_data(fwd_d),
    .rs1_addr(in_rs1_addr), .rs2_addr(in_rs2_addr),
    .rs1_data(in_rs1_data), .rs2_data(in_use_imm ? in_imm : in_rs2_data),
    .b_is_imm(in_use_imm), .a(cap_a), .b(cap_b)
  );

  alu_issue_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_main (
    .fwd_valid(fwd_v), .fwd_rd(fwd_r), .fwd_data(fwd_d),
    .rs1_addr(main_q.rs1), .rs2_addr(main_q.rs2),
    .rs1_data(main_q.a), .rs2_data(main_q.b),
    .b_is_imm(main_q.use_imm), .a(main_a), .b(main_b)
  );

  alu_issue_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_skid (
    .fwd_valid(fwd_v), .fwd_rd(fwd_r), .fwd_data(fwd_d),
    .rs1_addr(skid_q.rs1), .rs2_addr(skid_q.rs2),
    .rs1_data(skid_q.a), .rs2_data(skid_q.b),
    .b_is_imm(skid_q.use_imm), .a(skid_a), .b(skid_b)
  );

  // Build the incoming entry; illegal opcodes never carry a register write.
  always_comb begin
    cap           = '0;
    cap.a         = cap_a;
    cap.b         = cap_b;
    cap.op        = in_alu_control;
    cap.rd        = in_rd;
    cap.illegal   = ~op_is_legal(in_alu_control);
    cap.reg_write = in_reg_write & op_is_legal(in_alu_control);
    cap.use_imm   = in_use_imm;
`ifdef FORWARDING_EN
    cap.rs1       = in_rs1_addr;
    cap.rs2       = in_rs2_addr;
`endif
  end

  // Held entries with any same-cycle writeback refresh applied.
  always_comb begin
    main_ref   = main_q;
    main_ref.a = main_a;
    main_ref.b = main_b;
    skid_ref   = skid_q;
    skid_ref.a = skid_a;
    skid_ref.b = skid_b;
  end

  // Entry FSM with registered handshake outputs; flush beats accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      main_q <= main_ref;
      skid_q <= skid_ref;
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_q    <= cap;
            state     <= ST_FULL;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && !consume) begin
            skid_q   <= cap;
            state    <= ST_SKID;
            in_ready <= 1'b0;
          end else if (accept) begin
            main_q <= cap;
          end else if (consume) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_SKID: begin
          if (consume) begin
            main_q   <= skid_ref;
            state    <= ST_FULL;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_a           = main_q.a;
  assign out_b           = main_q.b;
  assign out_alu_control = main_q.op;
  assign out_rd          = main_q.rd;
  assign out_reg_write   = main_q.reg_write;
  assign out_illegal     = main_q.illegal;

endmodule
